// File: rtl/fipo_frame_loader.sv
// rtl/fipo_frame_loader.sv - beat-wise shadow loader with atomic commit to the parallel frame output
// Optional FIPO_FRAME_PARITY_EN: adds parity_in/parity_err; a parity mismatch suppresses the commit.
module fipo_frame_loader #(
    parameter  int DATA_W = 312,
    parameter  int LANE_W = 1,
    localparam int BEATS  = DATA_W / LANE_W,
    localparam int CNT_W  = $clog2(BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [LANE_W-1:0] serial_in,
    input  logic              abort,
    input  logic              clear_ovf,
`ifdef FIPO_FRAME_PARITY_EN
    input  logic              parity_in,
    output logic              parity_err,
`endif
    output logic [DATA_W-1:0] parallel_out,
    output logic [CNT_W-1:0]  beat_count,
    output logic              loading,
    output logic              data_written,
    output logic              end_writing,
    output logic              overflow
);

    generate
        if (DATA_W % LANE_W != 0) begin : g_bad_width
            $error("fipo_frame_loader: DATA_W must be a multiple of LANE_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shadow;
    logic              accept;
    logic              last_beat;
    logic              ovf_set;
    logic              parity_ok;
    logic              do_commit;

`ifdef FIPO_FRAME_PARITY_EN
    logic parity_q;

    assign parity_ok = ((^shadow) == parity_q);
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        loading   = 1'b0;
        accept    = 1'b0;
        ovf_set   = 1'b0;
        do_commit = 1'b0;
        last_beat = (beat_count == CNT_W'(BEATS - 1));
        case (state)
            IDLE, LOAD: begin
                loading = (state == LOAD);
                accept  = enable && !abort;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    state_nxt = last_beat ? COMMIT : LOAD;
                end
            end
            COMMIT: begin
                // abort is deliberately ignored here so the frame always resolves
                ovf_set   = enable;
                do_commit = parity_ok;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow       <= '0;
            parallel_out <= '0;
            beat_count   <= '0;
            data_written <= 1'b0;
            end_writing  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            data_written <= accept;
            end_writing  <= do_commit;
            // constant-index lane decode keeps the write free of wide variable selects
            for (int k = 0; k < BEATS; k++) begin
                if (accept && beat_count == CNT_W'(k)) begin
                    shadow[k*LANE_W +: LANE_W] <= serial_in;
                end
            end
            if (accept) begin
                beat_count <= beat_count + CNT_W'(1);
            end else if (abort || state == COMMIT) begin
                beat_count <= '0;
            end
            if (do_commit) begin
                parallel_out <= shadow;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef FIPO_FRAME_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (accept && last_beat) begin
                parity_q <= parity_in;
            end
            parity_err <= (state == COMMIT) && !parity_ok;
        end
    end
`endif

endmodule
